// File: rtl/mac_tc_pkg.sv
// Shared types and helpers for the MAC tensor-core array sequencer.
package mac_tc_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_CLEAR} sched_state_t;

  // Width of a batch index able to address 0..k_max-1 (at least 1 bit).
  function automatic int zw(input int k_max);
    return (k_max > 1) ? $clog2(k_max) : 1;
  endfunction

  // Number of FEED cycles for a job of k batches on an n x n array:
  // the far corner lane starts 2*(n-1) cycles after lane (0,0).
  function automatic int feed_len(input int n, input int k);
    return 2 * (n - 1) + k;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_tc_skew_lane.sv
// Read-enable / batch-index decode for one lane (i,j) of the skewed array feed.
// Lane (i,j) lags lane (0,0) by i+j cycles, so it reads batch cnt-(i+j).
module mac_tc_skew_lane
  import mac_tc_pkg::*;
#(
  parameter int I  = 0,
  parameter int J  = 0,
  parameter int CW = 6,
  parameter int KW = 6,
  parameter int ZW = 5
) (
  input  logic [CW-1:0] cnt,
  input  logic [KW-1:0] k_q,
  input  logic          feed,
  output logic          rd_en,
  output logic [ZW-1:0] rd_z
);

  // Signed width wide enough for cnt, k_q and a sign bit.
  localparam int DW = max2(max2(ZW + 2, CW + 1), KW + 1);
  localparam logic signed [DW-1:0] OFS = DW'(I + J);

  logic signed [DW-1:0] d;
  logic signed [DW-1:0] k_s;
  logic                 hit;

  assign d   = $signed({{(DW-CW){1'b0}}, cnt}) - OFS;
  assign k_s = $signed({{(DW-KW){1'b0}}, k_q});

  // Enabled while the lane's skewed batch index lies in 0..k_q-1.
  assign hit   = feed && !d[DW-1] && (d < k_s);
  assign rd_en = hit;
  assign rd_z  = hit ? d[ZW-1:0] : '0;

endmodule

// File: rtl/mac_tc_array_sched.sv
// Sequencer for the N x N MAC tensor-core array: feeds one batched GEMM with
// diagonal-skewed per-lane reads, waits for the array drain, clears the
// accumulators and reports completion.
module mac_tc_array_sched
  import mac_tc_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int K_MAX     = 32,
  parameter  int DRAIN_CYC = 2 * N + K_MAX,
  localparam int KW        = $clog2(K_MAX + 1),
  localparam int ZW        = zw(K_MAX),
  localparam int CW        = $clog2(max2(2 * N - 2 + K_MAX, DRAIN_CYC) + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [KW-1:0]     cfg_k,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [N*N-1:0]    rd_en,
  output logic [N*N*ZW-1:0] rd_z,
  output logic              data_valid,
  output logic              clc
);

  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

  sched_state_t  state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [KW-1:0] k_q_reg, k_q_next;
  logic          aborted_reg, aborted_next;
  logic          done_reg, done_next;
  logic          cfg_err_reg, cfg_err_next;

  logic [CW-1:0] feed_last;
  logic          cfg_ok;
  logic          feed;

  assign feed_last = CW'(feed_len(N, int'(k_q_reg)) - 1);
  assign cfg_ok    = (cfg_k != '0) && (cfg_k <= KW'(K_MAX));
  assign feed      = (state_reg == S_FEED);

  // Next-state, counter and pulse logic of the job FSM.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    k_q_next     = k_q_reg;
    aborted_next = aborted_reg;
    done_next    = 1'b0;
    cfg_err_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            k_q_next     = cfg_k;
            cnt_next     = '0;
            aborted_next = 1'b0;
            state_next   = S_FEED;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (abort) begin
          cnt_next     = '0;
          aborted_next = 1'b1;
          state_next   = S_CLEAR;
        end else if (cnt_reg == feed_last) begin
          cnt_next   = '0;
          state_next = S_DRAIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          cnt_next     = '0;
          aborted_next = 1'b1;
          state_next   = S_CLEAR;
        end else if (cnt_reg == DRAIN_LAST) begin
          cnt_next   = '0;
          state_next = S_CLEAR;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_CLEAR: begin
        state_next = S_IDLE;
        done_next  = !aborted_reg;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State registers; reset returns to IDLE with all pulses low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      k_q_reg     <= '0;
      aborted_reg <= 1'b0;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      k_q_reg     <= k_q_next;
      aborted_reg <= aborted_next;
      done_reg    <= done_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  assign busy       = (state_reg != S_IDLE);
  assign data_valid = feed;
  assign clc        = (state_reg == S_CLEAR);
  assign done       = done_reg;
  assign cfg_err    = cfg_err_reg;

  // One skew decoder per lane; lane l = i*N + j.
  for (genvar gi = 0; gi < N * N; gi++) begin : g_lane
    mac_tc_skew_lane #(
      .I (gi / N),
      .J (gi % N),
      .CW(CW),
      .KW(KW),
      .ZW(ZW)
    ) u_lane (
      .cnt  (cnt_reg),
      .k_q  (k_q_reg),
      .feed (feed),
      .rd_en(rd_en[gi]),
      .rd_z (rd_z[gi*ZW +: ZW])
    );
  end

endmodule
